// File: rtl/irrigation_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_controller_if
// Description : Sensor/tick inputs and level/mode/countdown outputs of the
//               irrigation controller.
// Revision    : 1.0
// ============================================================================
interface irrigation_controller_if;
    logic       tick_1s;
    logic       soil_dry;
    logic       air_dry;
    logic       fill;
    logic       H;
    logic       M;
    logic       L;
    logic       Bs;
    logic       Vs;
    logic       Error;
    logic [3:0] bcd_10m;
    logic [3:0] bcd_1m;
    logic [3:0] bcd_10s;
    logic [3:0] bcd_1s;

    modport master (
        output tick_1s, soil_dry, air_dry, fill,
        input  H, M, L, Bs, Vs, Error, bcd_10m, bcd_1m, bcd_10s, bcd_1s
    );

    modport slave (
        input  tick_1s, soil_dry, air_dry, fill,
        output H, M, L, Bs, Vs, Error, bcd_10m, bcd_1m, bcd_10s, bcd_1s
    );
endinterface
`default_nettype wire

// File: rtl/irrigation_controller.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_controller
// Description : Irrigation mode FSM with tank-level model and BCD MM:SS
//               countdown to the next level drop.
// Revision    : 1.0
// ============================================================================
module irrigation_controller #(
    parameter int SPRINKLE_MIN = 5,
    parameter int DRIP_MIN     = 10
) (
    input  wire                      clock,
    input  wire                      rst,
    irrigation_controller_if.slave   bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_SPRINKLE = 2'd1;
    localparam logic [1:0] c_DRIP     = 2'd2;
    localparam logic [1:0] c_EMPTY    = 2'd3;

    localparam logic [3:0] c_S_TENS  = 4'(SPRINKLE_MIN / 10);
    localparam logic [3:0] c_S_UNITS = 4'(SPRINKLE_MIN % 10);
    localparam logic [3:0] c_D_TENS  = 4'(DRIP_MIN / 10);
    localparam logic [3:0] c_D_UNITS = 4'(DRIP_MIN % 10);

    logic [1:0] r_state;
    logic [1:0] r_level;
    logic [3:0] r_m10, r_m1, r_s10, r_s1;

    logic [1:0] w_next;
    logic       w_next_mode;
    logic       w_enter;
    logic       w_at_one;
    logic       w_reload;
    logic       w_drop;
    logic [3:0] w_per_tens, w_per_units;
    logic [3:0] w_dm10, w_dm1, w_ds10, w_ds1;

    always_comb begin
        w_next = c_IDLE;
        if (!bus.soil_dry)
            w_next = c_IDLE;
        else if (r_level == 2'd0)
            w_next = c_EMPTY;
        else if (bus.air_dry)
            w_next = c_SPRINKLE;
        else
            w_next = c_DRIP;
    end

    assign w_next_mode = (w_next == c_SPRINKLE) || (w_next == c_DRIP);
    assign w_enter     = w_next_mode && (w_next != r_state);
    assign w_at_one    = (r_m10 == 4'd0) && (r_m1 == 4'd0) && (r_s10 == 4'd0) && (r_s1 == 4'd1);
    // A tick at 00:01 ends the period; only counts while staying in the same mode.
    assign w_reload    = w_next_mode && !w_enter && bus.tick_1s && w_at_one;
    assign w_drop      = w_reload && (r_level != 2'd0);

    assign w_per_tens  = (w_next == c_SPRINKLE) ? c_S_TENS  : c_D_TENS;
    assign w_per_units = (w_next == c_SPRINKLE) ? c_S_UNITS : c_D_UNITS;

    always_comb begin
        w_dm10 = r_m10;
        w_dm1  = r_m1;
        w_ds10 = r_s10;
        w_ds1  = r_s1;
        if (r_s1 != 4'd0) begin
            w_ds1 = r_s1 - 4'd1;
        end else begin
            w_ds1 = 4'd9;
            if (r_s10 != 4'd0) begin
                w_ds10 = r_s10 - 4'd1;
            end else begin
                w_ds10 = 4'd5;
                if (r_m1 != 4'd0) begin
                    w_dm1 = r_m1 - 4'd1;
                end else begin
                    w_dm1  = 4'd9;
                    w_dm10 = (r_m10 != 4'd0) ? r_m10 - 4'd1 : 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_level <= 2'd3;
            r_m10   <= 4'd0;
            r_m1    <= 4'd0;
            r_s10   <= 4'd0;
            r_s1    <= 4'd0;
        end else begin
            r_state <= w_next;

            if (bus.fill)
                r_level <= 2'd3;
            else if (w_drop)
                r_level <= r_level - 2'd1;

            if (!w_next_mode) begin
                r_m10 <= 4'd0;
                r_m1  <= 4'd0;
                r_s10 <= 4'd0;
                r_s1  <= 4'd0;
            end else if (w_enter || w_reload) begin
                r_m10 <= w_per_tens;
                r_m1  <= w_per_units;
                r_s10 <= 4'd0;
                r_s1  <= 4'd0;
            end else if (bus.tick_1s) begin
                r_m10 <= w_dm10;
                r_m1  <= w_dm1;
                r_s10 <= w_ds10;
                r_s1  <= w_ds1;
            end
        end
    end

    assign bus.H       = (r_level == 2'd3);
    assign bus.M       = (r_level >= 2'd2);
    assign bus.L       = (r_level != 2'd0);
    assign bus.Bs      = (r_state == c_SPRINKLE);
    assign bus.Vs      = (r_state == c_DRIP);
    assign bus.Error   = (r_state == c_EMPTY);
    assign bus.bcd_10m = r_m10;
    assign bus.bcd_1m  = r_m1;
    assign bus.bcd_10s = r_s10;
    assign bus.bcd_1s  = r_s1;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irrigation_controller
// Description : Directed scoreboard bench for irrigation_controller.
// Revision    : 1.0
// ============================================================================
module tb_irrigation_controller;

    typedef struct {
        string       name;
        logic [2:0]  hml;
        logic        bs;
        logic        vs;
        logic        err;
        logic [15:0] bcd;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    irrigation_controller_if bus ();

    irrigation_controller #(
        .SPRINKLE_MIN (5),
        .DRIP_MIN     (10)
    ) u_dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Monitor: compare every queued expectation on the falling edge.
    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [21:0] act, req;
            e   = q.pop_front();
            act = {bus.H, bus.M, bus.L, bus.Bs, bus.Vs, bus.Error,
                   bus.bcd_10m, bus.bcd_1m, bus.bcd_10s, bus.bcd_1s};
            req = {e.hml, e.bs, e.vs, e.err, e.bcd};
            n_tests++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL %s: got HML=%b Bs=%b Vs=%b Err=%b cnt=%h, expected HML=%b Bs=%b Vs=%b Err=%b cnt=%h",
                         e.name, act[21:19], act[18], act[17], act[16], act[15:0],
                         req[21:19], req[18], req[17], req[16], req[15:0]);
            end
        end
    end

    task automatic expect_out(input string name, input logic [2:0] hml, input logic bs,
                              input logic vs, input logic err, input logic [15:0] bcd);
        exp_t e;
        e.name = name; e.hml = hml; e.bs = bs; e.vs = vs; e.err = err; e.bcd = bcd;
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic tk);
        bus.tick_1s = tk;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
        bus.tick_1s = 1'b0;
    endtask

    initial begin
        bus.tick_1s  = 1'b0;
        bus.soil_dry = 1'b0;
        bus.air_dry  = 1'b0;
        bus.fill     = 1'b0;

        run(2, 1'b0);
        rst = 1'b0;
        expect_out("reset", 3'b111, 0, 0, 0, 16'h0000);

        bus.air_dry = 1'b1;
        run(50, 1'b1);
        expect_out("air_only_idle", 3'b111, 0, 0, 0, 16'h0000);

        bus.soil_dry = 1'b1;
        run(1, 1'b1);
        expect_out("sprinkle_enter", 3'b111, 1, 0, 0, 16'h0500);
        run(1, 1'b1);
        expect_out("sprinkle_1tick", 3'b111, 1, 0, 0, 16'h0459);
        run(299, 1'b1);
        expect_out("sprinkle_300", 3'b011, 1, 0, 0, 16'h0500);
        run(600, 1'b1);
        expect_out("sprinkle_900", 3'b000, 1, 0, 0, 16'h0500);
        run(1, 1'b1);
        expect_out("empty", 3'b000, 0, 0, 1, 16'h0000);

        bus.fill = 1'b1;
        run(1, 1'b0);
        bus.fill = 1'b0;
        expect_out("fill_in_empty", 3'b111, 0, 0, 1, 16'h0000);
        run(1, 1'b0);
        expect_out("recover_sprinkle", 3'b111, 1, 0, 0, 16'h0500);

        run(299, 1'b1);
        expect_out("at_0001", 3'b111, 1, 0, 0, 16'h0001);
        bus.fill = 1'b1;
        run(1, 1'b1);
        bus.fill = 1'b0;
        expect_out("fill_with_drop", 3'b111, 1, 0, 0, 16'h0500);

        run(93, 1'b1);
        expect_out("at_0327", 3'b111, 1, 0, 0, 16'h0327);
        bus.air_dry = 1'b0;
        run(1, 1'b1);
        expect_out("switch_to_drip", 3'b111, 0, 1, 0, 16'h1000);

        run(600, 1'b1);
        expect_out("drip_600", 3'b011, 0, 1, 0, 16'h1000);
        run(1, 1'b1);
        expect_out("drip_borrow", 3'b011, 0, 1, 0, 16'h0959);
        bus.fill = 1'b1;
        run(1, 1'b0);
        bus.fill = 1'b0;
        expect_out("fill_in_drip", 3'b111, 0, 1, 0, 16'h0959);

        bus.soil_dry = 1'b0;
        run(1, 1'b1);
        expect_out("to_idle", 3'b111, 0, 0, 0, 16'h0000);

        bus.soil_dry = 1'b1;
        bus.air_dry  = 1'b1;
        run(1, 1'b0);
        expect_out("sprinkle_again", 3'b111, 1, 0, 0, 16'h0500);
        run(300, 1'b1);
        expect_out("level2", 3'b011, 1, 0, 0, 16'h0500);
        run(167, 1'b1);
        expect_out("at_0213", 3'b011, 1, 0, 0, 16'h0213);

        rst      = 1'b1;
        bus.fill = 1'b1;
        run(1, 1'b1);
        rst      = 1'b0;
        bus.fill = 1'b0;
        expect_out("reset_midop", 3'b111, 0, 0, 0, 16'h0000);

        run(1, 1'b0);
        expect_out("post_reset_sprinkle", 3'b111, 1, 0, 0, 16'h0500);
        run(600, 1'b1);
        expect_out("level1", 3'b001, 1, 0, 0, 16'h0500);

        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
